// File: rtl/coffee_brew_arbiter.sv
// coffee_brew_arbiter
//   Shares one brewing unit (cup dropper + brewer) between N_REQ vending
//   front-ends. Each req pulse becomes a sticky pending flag; pending ids are
//   served round-robin: drop cup for CUP_CYC cycles, brew for BREW_CYC cycles,
//   then pulse done[grant_id] for one cycle.
//
//   Optional feature macro: COFFEE_ARB_FAULT_EN
//     defined   -> cup_ok is sampled at the end of CUP; a missing cup goes to
//                  FAULT (one-cycle fault pulse, request dropped, no done).
//     undefined -> cup_ok ignored, fault tied to 0.
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous reset, active low
//   req       in   N_REQ  per-requester coffee pulse
//   cup_ok    in   1      cup-present sensor
//   cup_drop  out  1      cup dropper drive (state CUP)
//   brew_on   out  1      brewer drive (state BREW)
//   done      out  N_REQ  one-cycle pulse on bit grant_id when a cup is finished
//   fault     out  1      one-cycle pulse on missing cup
//   busy      out  1      high in every state except IDLE
//   grant_id  out  2      index being served; holds last value while IDLE
//   pending   out  N_REQ  registered pending-request flags
module coffee_brew_arbiter #(
    parameter int N_REQ    = 2,
    parameter int CUP_CYC  = 2,
    parameter int BREW_CYC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             cup_ok,
    output logic             cup_drop,
    output logic             brew_on,
    output logic [N_REQ-1:0] done,
    output logic             fault,
    output logic             busy,
    output logic [1:0]       grant_id,
    output logic [N_REQ-1:0] pending
);

    typedef enum logic [2:0] {
        IDLE,
        CUP,
        BREW,
`ifdef COFFEE_ARB_FAULT_EN
        DONE,
        FAULT
`else
        DONE
`endif
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic [1:0]        ptr, ptr_nxt;
    logic [1:0]        gid_nxt;
    logic [1:0]        pick, pick_hi, pick_lo;
    logic              hit_hi, hit_lo;
    logic [N_REQ-1:0]  gmask;
    logic [N_REQ-1:0]  clr;
    logic              serve_end;
    // Re-request from the id currently being served; keeps its pending flag
    // alive through the clear in DONE/FAULT so it gets a second service.
    logic              rereq;

    // Round-robin pick: first pending id above ptr, else first at/below ptr.
    always_comb begin
        hit_hi  = 1'b0;
        hit_lo  = 1'b0;
        pick_hi = '0;
        pick_lo = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pending[i]) begin
                if (i > 32'(ptr) && !hit_hi) begin
                    hit_hi  = 1'b1;
                    pick_hi = 2'(i);
                end
                if (i <= 32'(ptr) && !hit_lo) begin
                    hit_lo  = 1'b1;
                    pick_lo = 2'(i);
                end
            end
        end
        pick = hit_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        gmask = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            gmask[i] = (32'(grant_id) == i);
        end
    end

`ifdef COFFEE_ARB_FAULT_EN
    assign serve_end = (state == DONE) || (state == FAULT);
    assign fault     = (state == FAULT);
`else
    logic unused_cup_ok;
    assign unused_cup_ok = cup_ok;
    assign serve_end     = (state == DONE);
    assign fault         = 1'b0;
`endif

    assign clr      = (serve_end && !rereq) ? gmask : '0;
    assign cup_drop = (state == CUP);
    assign brew_on  = (state == BREW);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE) ? gmask : '0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        gid_nxt   = grant_id;
        case (state)
            IDLE: begin
                if (|pending) begin
                    state_nxt = CUP;
                    cnt_nxt   = 8'(CUP_CYC - 1);
                    gid_nxt   = pick;
                    ptr_nxt   = pick;
                end
            end
            CUP: begin
                if (cnt == 8'd0) begin
`ifdef COFFEE_ARB_FAULT_EN
                    if (cup_ok) begin
                        state_nxt = BREW;
                        cnt_nxt   = 8'(BREW_CYC - 1);
                    end else begin
                        state_nxt = FAULT;
                        cnt_nxt   = '0;
                    end
`else
                    state_nxt = BREW;
                    cnt_nxt   = 8'(BREW_CYC - 1);
`endif
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            BREW: begin
                if (cnt == 8'd0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ptr      <= 2'(N_REQ - 1);
            grant_id <= '0;
            pending  <= '0;
            rereq    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ptr      <= ptr_nxt;
            grant_id <= gid_nxt;
            pending  <= req | (pending & ~clr);
            if (state == CUP || state == BREW) begin
                rereq <= rereq | (|(req & gmask));
            end else if (state == IDLE) begin
                rereq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_coffee_brew_arbiter.sv
// tb_coffee_brew_arbiter
//   Directed bench for coffee_brew_arbiter (N_REQ=2, CUP_CYC=2, BREW_CYC=8):
//   a per-cycle vector table for a single service, then hand-written
//   sequences for round-robin order, re-requests, held requests, cup fault
//   and asynchronous reset.
module tb_coffee_brew_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic       cup_ok;
    logic       cup_drop, brew_on, fault, busy;
    logic [1:0] done, grant_id, pending;

    coffee_brew_arbiter #(.N_REQ(2), .CUP_CYC(2), .BREW_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cup_ok(cup_ok),
        .cup_drop(cup_drop), .brew_on(brew_on), .done(done), .fault(fault),
        .busy(busy), .grant_id(grant_id), .pending(pending)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Monitor: cycle count, done/fault pulses and service order.
    int cyc     = 0;
    int n_done  = 0;
    int n_fault = 0;
    int order[$];
    int done_cyc[2];

    always @(negedge clk) begin
        cyc++;
        if (done[0]) begin n_done++; order.push_back(0); done_cyc[0] = cyc; end
        if (done[1]) begin n_done++; order.push_back(1); done_cyc[1] = cyc; end
        if (fault) n_fault++;
    end

    // {cup_drop, brew_on, done[1:0], fault, busy, grant_id[1:0], pending[1:0]}
    function automatic logic [10:0] outs();
        return {cup_drop, brew_on, done, fault, busy, grant_id, pending};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ord(input int i);
        return (i < order.size()) ? order[i] : -1;
    endfunction

    task automatic wait_dones(input int target, input int budget, input string name);
        int k = 0;
        while (n_done < target && k < budget) begin step(); k++; end
        step();
        check(name, 32'(n_done >= target), 32'd1);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((busy || pending != 2'b00) && k < 40) begin step(); k++; end
        check(name, {30'd0, busy, |pending}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [10:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] r, input logic cd, input logic bo,
                                input logic [1:0] dn, input logic bz,
                                input logic [1:0] gid, input logic [1:0] pend);
        vec_t v;
        v.req = r;
        v.exp = {cd, bo, dn, 1'b0, bz, gid, pend};
        return v;
    endfunction

    vec_t vt[15];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, ob, fb, k;

        // Single request from id0, then a request from id1 to show rotation.
        vt[0]  = mk(2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'b01);
        vt[1]  = mk(2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 2'd0, 2'b01);
        vt[2]  = mk(2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 2'd0, 2'b01);
        for (int i = 3; i <= 10; i++)
            vt[i] = mk(2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 2'd0, 2'b01);
        vt[11] = mk(2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 2'd0, 2'b01);
        vt[12] = mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'b00);
        vt[13] = mk(2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'b10);
        vt[14] = mk(2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 2'd1, 2'b10);

        rst_n  = 1'b0;
        req    = 2'b00;
        cup_ok = 1'b1;
        step();
        step();
        check("reset_outputs", 32'(outs()), 32'd0);
        rst_n = 1'b1;
        step();

        // Table: single service timeline.
        for (int i = 0; i < 15; i++) begin
            req = vt[i].req;
            step();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
        end
        req = 2'b00;
        drain("drain_table");

        // Both requests in one cycle: id0 then id1, 12 cycles apart.
        base = n_done; ob = order.size();
        req = 2'b11; step(); req = 2'b00;
        wait_dones(base + 2, 60, "rr_two_timeout");
        check("rr_two_order", 32'({ord(ob) == 0, ord(ob + 1) == 1}), 32'b11);
        check("rr_two_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'd12);
        drain("drain_rr_two");

        // Re-request from id0 during its BREW: order 0,1,0 and exactly 3 dones.
        base = n_done; ob = order.size();
        req = 2'b11; step(); req = 2'b00;
        k = 0;
        while (!(brew_on && grant_id == 2'd0) && k < 40) begin step(); k++; end
        check("rereq_brew_seen", 32'(brew_on && grant_id == 2'd0), 32'd1);
        req = 2'b01; step(); req = 2'b00;
        wait_dones(base + 3, 80, "rereq_timeout");
        repeat (30) step();
        check("rereq_count", 32'(n_done - base), 32'd3);
        check("rereq_order", 32'({ord(ob) == 0, ord(ob + 1) == 1, ord(ob + 2) == 0}), 32'b111);

        // req[1] held 5 cycles while id0 is being served: a single service of id1.
        base = n_done; ob = order.size();
        req = 2'b01; step();
        req = 2'b10;
        repeat (5) step();
        check("held_pending", {28'd0, grant_id, pending}, {28'd0, 2'd0, 2'b11});
        req = 2'b00;
        wait_dones(base + 2, 80, "held_timeout");
        repeat (30) step();
        check("held_count", 32'(n_done - base), 32'd2);
        check("held_order", 32'({ord(ob) == 0, ord(ob + 1) == 1}), 32'b11);

        // Missing cup on id0 with id1 pending.
        base = n_done; ob = order.size(); fb = n_fault;
`ifdef COFFEE_ARB_FAULT_EN
        req = 2'b11; step(); req = 2'b00;
        cup_ok = 1'b0;
        k = 0;
        while (!fault && k < 40) begin step(); k++; end
        check("fault_pulse", {30'd0, fault, grant_id == 2'd0}, 32'b11);
        cup_ok = 1'b1;
        step();
        check("fault_after", {29'd0, fault, pending}, {29'd0, 1'b0, 2'b10});
        step();
        check("fault_next_grant", {29'd0, cup_drop, grant_id}, {29'd0, 1'b1, 2'd1});
        wait_dones(base + 1, 40, "fault_timeout");
        repeat (10) step();
        check("fault_done_count", 32'(n_done - base), 32'd1);
        check("fault_order", 32'(ord(ob)), 32'd1);
        check("fault_count", 32'(n_fault - fb), 32'd1);
`else
        req = 2'b11; step(); req = 2'b00;
        cup_ok = 1'b0;
        wait_dones(base + 2, 60, "nocup_timeout");
        cup_ok = 1'b1;
        check("nocup_order", 32'({ord(ob) == 0, ord(ob + 1) == 1}), 32'b11);
        check("nocup_fault", 32'(n_fault - fb), 32'd0);
`endif
        drain("drain_cup");

        // Async reset mid-BREW of id0 with id1 pending: all clear, no done, id0 first.
        req = 2'b01; step(); req = 2'b00;
        k = 0;
        while (!brew_on && k < 40) begin step(); k++; end
        check("abort_brew_seen", {30'd0, brew_on, grant_id == 2'd0}, 32'b11);
        req = 2'b10; step(); req = 2'b00;
        base = n_done;
        #2 rst_n = 1'b0;
        #1 check("abort_outputs", 32'(outs()), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("abort_no_done", 32'(n_done - base), 32'd0);
        ob = order.size();
        req = 2'b11; step(); req = 2'b00;
        wait_dones(base + 1, 40, "abort_timeout");
        check("abort_first_grant", 32'(ord(ob)), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
